// File: rtl/hazard_pkg.sv
// Shared hazard-control definitions: FPU opcodes, sequencer state encoding and
// the pipeline stall/flush control bundle.
package hazard_pkg;

  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned FPU_OP_W  = 5;
  localparam int unsigned WD_W      = 8;

  localparam logic [FPU_OP_W-1:0] FPU_FDIV  = 5'd3;
  localparam logic [FPU_OP_W-1:0] FPU_FSQRT = 5'd4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } fpu_state_e;

  typedef struct packed {
    logic stall_f;
    logic stall_d;
    logic stall_e;
    logic flush_d;
    logic flush_e;
    logic flush_m;
  } pipe_ctl_t;

  // Opcodes that run on the multi-cycle FPU datapath.
  function automatic logic is_multi_op(input logic [FPU_OP_W-1:0] op);
    return (op == FPU_FDIV) || (op == FPU_FSQRT);
  endfunction

endpackage

// File: rtl/hazard_sched_unit_if.sv
// Pipeline-to-hazard-unit bundle: ID/EX hazard sources, FPU handshake and
// the stall/flush controls returned to the pipeline registers.
interface hazard_sched_unit_if #(
  parameter int unsigned CNT_W = 32
);
  import hazard_pkg::*;

  logic [REG_IDX_W-1:0] RS1_D, RS2_D;
  logic                 UseRs1D, UseRs2D;
  logic [REG_IDX_W-1:0] FP_RS1_D, FP_RS2_D;
  logic                 UseFRs1D, UseFRs2D;
  logic [REG_IDX_W-1:0] RD_E;
  logic                 RegWriteE;
  logic                 ResultSrcE;
  logic [REG_IDX_W-1:0] FP_RD_E;
  logic                 FPLoadE;
  logic                 isFPUE;
  logic [FPU_OP_W-1:0]  FPUControlE;
  logic                 PCSrcE;
  logic                 fpu_done;

  logic                 StallF, StallD, StallE;
  logic                 FlushD, FlushE, FlushM;
  logic                 fpu_start;
  logic                 fpu_busy;
  logic                 fpu_timeout;
  logic [CNT_W-1:0]     stall_cnt;

  // Pipeline / FPU side.
  modport master (
    output RS1_D, RS2_D, UseRs1D, UseRs2D,
    output FP_RS1_D, FP_RS2_D, UseFRs1D, UseFRs2D,
    output RD_E, RegWriteE, ResultSrcE, FP_RD_E, FPLoadE,
    output isFPUE, FPUControlE, PCSrcE, fpu_done,
    input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
    input  fpu_start, fpu_busy, fpu_timeout, stall_cnt
  );

  // Hazard unit side.
  modport slave (
    input  RS1_D, RS2_D, UseRs1D, UseRs2D,
    input  FP_RS1_D, FP_RS2_D, UseFRs1D, UseFRs2D,
    input  RD_E, RegWriteE, ResultSrcE, FP_RD_E, FPLoadE,
    input  isFPUE, FPUControlE, PCSrcE, fpu_done,
    output StallF, StallD, StallE, FlushD, FlushE, FlushM,
    output fpu_start, fpu_busy, fpu_timeout, stall_cnt
  );

endinterface

// File: rtl/fpu_seq_fsm.sv
// Multi-cycle FPU sequencer: launches FDIV/FSQRT, holds the front of the pipe
// until done or watchdog expiry, and records a sticky timeout.
module fpu_seq_fsm
  import hazard_pkg::*;
#(
  parameter int unsigned MAX_FPU_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic start_req,
  input  logic fpu_done,
  output logic fpu_start,
  output logic fpu_busy,
  output logic hold_c,
  output logic fpu_timeout
);

  localparam logic [WD_W-1:0] WD_LAST = WD_W'(MAX_FPU_CYCLES - 1);

  fpu_state_e      state_q, state_nx;
  logic [WD_W-1:0] cnt_q, cnt_nx;
  logic            timeout_q, timeout_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_nx;
      cnt_q     <= cnt_nx;
      timeout_q <= timeout_nx;
    end
  end

  // Release on done or on the last watchdog cycle; otherwise keep holding.
  always_comb begin
    state_nx   = state_q;
    cnt_nx     = cnt_q;
    timeout_nx = timeout_q;
    fpu_start  = 1'b0;
    fpu_busy   = 1'b0;
    hold_c     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_req) begin
          fpu_start = 1'b1;
          hold_c    = 1'b1;
          state_nx  = BUSY;
          cnt_nx    = '0;
        end
      end
      BUSY: begin
        fpu_busy = 1'b1;
        if (fpu_done) begin
          state_nx = IDLE;
        end else if (cnt_q == WD_LAST) begin
          state_nx   = IDLE;
          timeout_nx = 1'b1;
        end else begin
          hold_c = 1'b1;
          cnt_nx = cnt_q + WD_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign fpu_timeout = timeout_q;

endmodule

// File: rtl/hazard_sched_unit.sv
// Pipeline hazard controller: load-use stalls, branch flushes, multi-cycle FPU
// sequencing and a stall-cycle performance counter.
module hazard_sched_unit
  import hazard_pkg::*;
#(
  parameter int unsigned MAX_FPU_CYCLES = 64,
  parameter int unsigned CNT_W          = 32
) (
  input logic                clk,
  input logic                rst,
  hazard_sched_unit_if.slave bus
);

  logic             multi_e;
  logic             lu_i;
  logic             lu_f;
  logic             hold_c;
  logic             fpu_start;
  logic             fpu_busy;
  logic             fpu_timeout;
  pipe_ctl_t        ctl;
  logic [CNT_W-1:0] stall_cnt_q;

  assign multi_e = bus.isFPUE && is_multi_op(bus.FPUControlE);

  assign lu_i = bus.ResultSrcE && bus.RegWriteE && (bus.RD_E != '0) &&
                ((bus.UseRs1D && (bus.RD_E == bus.RS1_D)) ||
                 (bus.UseRs2D && (bus.RD_E == bus.RS2_D)));

  // f0 is a real FP register, so no zero-index exclusion here.
  assign lu_f = bus.FPLoadE &&
                ((bus.UseFRs1D && (bus.FP_RD_E == bus.FP_RS1_D)) ||
                 (bus.UseFRs2D && (bus.FP_RD_E == bus.FP_RS2_D)));

  fpu_seq_fsm #(
    .MAX_FPU_CYCLES(MAX_FPU_CYCLES)
  ) u_fpu_seq (
    .clk        (clk),
    .rst        (rst),
    .start_req  (multi_e && !bus.PCSrcE),
    .fpu_done   (bus.fpu_done),
    .fpu_start  (fpu_start),
    .fpu_busy   (fpu_busy),
    .hold_c     (hold_c),
    .fpu_timeout(fpu_timeout)
  );

  // FPU hold wins; while busy, branch and load-use requests are ignored.
  always_comb begin
    ctl = '0;
    if (hold_c) begin
      ctl.stall_f = 1'b1;
      ctl.stall_d = 1'b1;
      ctl.stall_e = 1'b1;
      ctl.flush_m = 1'b1;
    end else if (!fpu_busy) begin
      if (bus.PCSrcE) begin
        ctl.flush_d = 1'b1;
        ctl.flush_e = 1'b1;
      end else if (lu_i || lu_f) begin
        ctl.stall_f = 1'b1;
        ctl.stall_d = 1'b1;
        ctl.flush_e = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (ctl.stall_f) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign bus.StallF      = ctl.stall_f;
  assign bus.StallD      = ctl.stall_d;
  assign bus.StallE      = ctl.stall_e;
  assign bus.FlushD      = ctl.flush_d;
  assign bus.FlushE      = ctl.flush_e;
  assign bus.FlushM      = ctl.flush_m;
  assign bus.fpu_start   = fpu_start;
  assign bus.fpu_busy    = fpu_busy;
  assign bus.fpu_timeout = fpu_timeout;
  assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_sched_unit.sv
// Directed bench for hazard_sched_unit with a queue of expected control vectors
// and a stall-count reference.
module tb_hazard_sched_unit;

  localparam int unsigned CNT_W = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hazard_sched_unit_if #(.CNT_W(CNT_W)) bus ();

  hazard_sched_unit #(
    .MAX_FPU_CYCLES(8),
    .CNT_W         (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // {StallF,StallD,StallE,FlushD,FlushE,FlushM,fpu_start,fpu_busy,fpu_timeout}
  localparam logic [8:0] E_NONE   = 9'b000_000_000;
  localparam logic [8:0] E_LU     = 9'b110_010_000;
  localparam logic [8:0] E_BR     = 9'b000_110_000;
  localparam logic [8:0] E_START  = 9'b111_001_100;
  localparam logic [8:0] E_BUSY   = 9'b111_001_010;
  localparam logic [8:0] E_REL    = 9'b000_000_010;
  localparam logic [8:0] E_TO     = 9'b000_000_001;

  logic [8:0]       exp_q[$];
  logic [CNT_W-1:0] model_cnt = '0;
  int               n_checks  = 0;
  int               n_fail    = 0;

  task automatic clear_inputs();
    bus.RS1_D = '0; bus.RS2_D = '0; bus.UseRs1D = 1'b0; bus.UseRs2D = 1'b0;
    bus.FP_RS1_D = '0; bus.FP_RS2_D = '0; bus.UseFRs1D = 1'b0; bus.UseFRs2D = 1'b0;
    bus.RD_E = '0; bus.RegWriteE = 1'b0; bus.ResultSrcE = 1'b0;
    bus.FP_RD_E = '0; bus.FPLoadE = 1'b0;
    bus.isFPUE = 1'b0; bus.FPUControlE = '0; bus.PCSrcE = 1'b0; bus.fpu_done = 1'b0;
  endtask

  task automatic set_int_lu(input logic [4:0] rd);
    bus.ResultSrcE = 1'b1; bus.RegWriteE = 1'b1; bus.RD_E = rd;
    bus.RS2_D = rd; bus.UseRs2D = 1'b1;
  endtask

  task automatic set_fpu(input logic [4:0] op);
    bus.isFPUE = 1'b1; bus.FPUControlE = op;
  endtask

  // One clock: inputs already driven; compare at negedge, then advance.
  task automatic cyc(input string tag, input logic [8:0] exp);
    logic [8:0] e;
    logic [8:0] got;
    exp_q.push_back(exp);
    @(negedge clk);
    e   = exp_q.pop_front();
    got = {bus.StallF, bus.StallD, bus.StallE, bus.FlushD, bus.FlushE, bus.FlushM,
           bus.fpu_start, bus.fpu_busy, bus.fpu_timeout};
    n_checks++;
    assert (got === e) else begin
      n_fail++;
      $error("FAIL %s ctl: observed %b expected %b", tag, got, e);
    end
    n_checks++;
    assert (bus.stall_cnt === model_cnt) else begin
      n_fail++;
      $error("FAIL %s stall_cnt: observed %0d expected %0d", tag, bus.stall_cnt, model_cnt);
    end
    @(posedge clk);
    if (rst) model_cnt = '0;
    else if (e[8]) model_cnt = model_cnt + CNT_W'(1);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    @(posedge clk);
    #1;
    cyc("reset0", E_NONE);
    cyc("reset1", E_NONE);
    rst = 1'b0;

    // Integer load-use, then RD=0 and unused source.
    set_int_lu(5'd5);                 cyc("int_lu", E_LU);
    clear_inputs();                   cyc("int_lu_after", E_NONE);
    set_int_lu(5'd0);                 cyc("int_lu_x0", E_NONE);
    set_int_lu(5'd9); bus.UseRs2D = 1'b0; cyc("int_lu_unused", E_NONE);
    clear_inputs();
    bus.ResultSrcE = 1'b1; bus.RegWriteE = 1'b1; bus.RD_E = 5'd7;
    bus.RS1_D = 5'd7; bus.UseRs1D = 1'b1; cyc("int_lu_rs1", E_LU);
    bus.RegWriteE = 1'b0;             cyc("int_lu_nowr", E_NONE);
    clear_inputs();

    // FP load-use on f0.
    bus.FPLoadE = 1'b1; bus.FP_RD_E = 5'd0; bus.FP_RS1_D = 5'd0; bus.UseFRs1D = 1'b1;
    cyc("fp_lu_f0", E_LU);
    clear_inputs();
    bus.FPLoadE = 1'b1; bus.FP_RD_E = 5'd12; bus.FP_RS2_D = 5'd13; bus.UseFRs2D = 1'b1;
    cyc("fp_lu_nomatch", E_NONE);
    clear_inputs();

    // Branch beats load-use.
    set_int_lu(5'd5); bus.PCSrcE = 1'b1; cyc("branch_lu", E_BR);
    clear_inputs();
    bus.fpu_done = 1'b1;              cyc("done_idle", E_NONE);
    clear_inputs();
    set_fpu(5'd1);                    cyc("fpu_single", E_NONE);
    bus.isFPUE = 1'b0; bus.FPUControlE = 5'd3; cyc("fdiv_notfpu", E_NONE);
    clear_inputs();

    // FDIV, done 6 cycles after start; branch mid-op is ignored.
    set_fpu(5'd3);                    cyc("fdiv_start", E_START);
    for (int i = 1; i <= 5; i++) begin
      bus.PCSrcE = (i == 3);
      cyc("fdiv_busy", E_BUSY);
    end
    bus.PCSrcE = 1'b0; bus.fpu_done = 1'b1; cyc("fdiv_done", E_REL);
    clear_inputs();                   cyc("fdiv_after", E_NONE);

    // FSQRT with no done: watchdog after 8 stalled cycles.
    set_fpu(5'd4);                    cyc("fsqrt_start", E_START);
    for (int i = 0; i < 7; i++) cyc("fsqrt_busy", E_BUSY);
    cyc("fsqrt_timeout_rel", E_REL);
    // Back-to-back op re-launches; done at minimum latency.
    cyc("b2b_start", E_START | E_TO);
    bus.fpu_done = 1'b1;              cyc("b2b_done", E_REL | E_TO);
    clear_inputs();                   cyc("timeout_sticky", E_TO);
    set_int_lu(5'd5);                 cyc("lu_with_to", E_LU | E_TO);
    clear_inputs();

    // Reset on the 3rd BUSY cycle aborts the op.
    set_fpu(5'd3);                    cyc("rst_start", E_START | E_TO);
    cyc("rst_busy1", E_BUSY | E_TO);
    cyc("rst_busy2", E_BUSY | E_TO);
    rst = 1'b1;                       cyc("rst_busy3", E_BUSY | E_TO);
    rst = 1'b0; clear_inputs();       cyc("rst_after", E_NONE);
    set_int_lu(5'd5);                 cyc("post_rst_lu", E_LU);
    clear_inputs();                   cyc("post_rst_idle", E_NONE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_sched_unit.md
Name: hazard_sched_unit

Overview:
- Pipeline hazard controller that drives the stall/flush inputs of the IF/ID, ID/EX and EX/MEM registers in each core.
- Detects integer and FP load-use hazards and handles branch-taken flushes.
- Sequences multi-cycle FPU operations (FDIV, FSQRT) through a start/done handshake, freezing the front of the pipeline until the FPU completes or times out.
- Keeps a free-running stall-cycle performance counter.

Parameters:
- MAX_FPU_CYCLES, 64, watchdog limit in cycles for a multi-cycle FPU op (legal range 2..255).
- CNT_W, 32, width of the stall performance counter.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- RS1_D, RS2_D  in  5 each  integer source indices in ID
- UseRs1D, UseRs2D  in  1 each  the ID instruction reads the integer source
- FP_RS1_D, FP_RS2_D  in  5 each  FP source indices in ID
- UseFRs1D, UseFRs2D  in  1 each  the ID instruction reads the FP source
- RD_E  in  5  integer destination in EX
- RegWriteE  in  1  EX writes the integer RF
- ResultSrcE  in  1  EX instruction is a load
- FP_RD_E  in  5  FP destination in EX
- FPLoadE  in  1  EX instruction is FLW
- isFPUE  in  1  EX instruction is an FPU op
- FPUControlE  in  5  FPU opcode in EX
- PCSrcE  in  1  branch/jump taken, resolved in EX
- fpu_done  in  1  single-cycle pulse: multi-cycle result valid
- StallF, StallD, StallE  out  1 each  hold PC, IF/ID, ID/EX
- FlushD, FlushE, FlushM  out  1 each  bubble IF/ID, ID/EX, EX/MEM
- fpu_start  out  1  single-cycle pulse launching a multi-cycle op
- fpu_busy  out  1  FSM in BUSY
- fpu_timeout  out  1  sticky watchdog error
- stall_cnt  out  CNT_W  cycles with StallF=1

Behaviour:
- Reset: while rst=1 at a posedge, state<=IDLE, cycle counter<=0, fpu_timeout<=0, stall_cnt<=0. All outputs are combinational from state/inputs and therefore read 0 in IDLE with idle inputs.
- MultiE = isFPUE && (FPUControlE==FPU_FDIV || FPUControlE==FPU_FSQRT).
- Integer load-use: LU_I = ResultSrcE && RegWriteE && RD_E!=0 && ((UseRs1D && RD_E==RS1_D) || (UseRs2D && RD_E==RS2_D)).
- FP load-use: LU_F = FPLoadE && ((UseFRs1D && FP_RD_E==FP_RS1_D) || (UseFRs2D && FP_RD_E==FP_RS2_D)). f0 is a real register, so there is no zero exclusion.
- IDLE, evaluated in this priority order:
  - PCSrcE: FlushD=FlushE=1, no stall; stays IDLE.
  - MultiE: fpu_start=1, StallF=StallD=StallE=1, FlushM=1; next state BUSY, cnt<=0.
  - LU_I or LU_F: StallF=StallD=1, FlushE=1 (1-cycle bubble).
- BUSY:
  - fpu_busy=1, StallF=StallD=StallE=1, FlushM=1. PCSrcE, LU_I and LU_F are ignored.
  - fpu_done=1: all stalls and FlushM deasserted this cycle so the op advances to MEM; next state IDLE.
  - No done and cnt==MAX_FPU_CYCLES-1: same release as done, fpu_timeout<=1 (sticky until rst), next state IDLE.
  - Otherwise cnt<=cnt+1.
- fpu_done in IDLE is ignored. Minimum FPU latency is one cycle after start.
- After release, the next cycle evaluates a fresh EX instruction. A back-to-back FDIV therefore re-enters BUSY with a new fpu_start.
- stall_cnt increments on each cycle with StallF=1 and wraps modulo 2^CNT_W.
- rst asserted mid-BUSY aborts to IDLE. The FPU is reset by the same rst.

Decomposition:
- Shared package hazard_pkg holds:
  - FPU_FDIV=5'd3 and FPU_FSQRT=5'd4 (shared with the decoder and FPU).
  - State encoding IDLE=1'b0, BUSY=1'b1.
- Natural sub-module: fpu_seq_fsm, containing the FSM, watchdog counter, fpu_start/fpu_busy/fpu_timeout and the BUSY stall terms.
- The top level holds the load-use comparators, branch flush, the priority mux and stall_cnt.

Test Plan:
- Int load-use: ResultSrcE=1, RegWriteE=1, RD_E=5, RS2_D=5, UseRs2D=1 -> StallF=StallD=FlushE=1 for exactly 1 cycle; stall_cnt=1. Repeat with RD_E=0 -> no stall.
- FP load-use: FPLoadE=1, FP_RD_E=0, FP_RS1_D=0, UseFRs1D=1 -> 1-cycle stall with FlushE=1.
- Branch vs load-use: PCSrcE=1 together with a LU_I condition -> FlushD=FlushE=1, StallF=0.
- FDIV: isFPUE=1, FPUControlE=3; fpu_done arrives 6 cycles after fpu_start -> fpu_start high for 1 cycle; StallE=FlushM=1 for 6 cycles; released on the done cycle; stall_cnt=6; fpu_timeout=0.
- Timeout: MAX_FPU_CYCLES=8, FSQRT with no done -> release after 8 stalled cycles; fpu_timeout=1 and stays high until rst.
- Mid-op reset: rst pulsed on the 3rd BUSY cycle -> next cycle fpu_busy=0, all stalls 0, stall_cnt=0, fpu_timeout=0.
